// File: rtl/unidade_controle_genius_param_pkg.sv
// Shared definitions for the memory-game control unit: 5-bit state codes seen by datapath and hex decoder.
// Latency: n/a (types only).
// Backpressure: n/a.
package unidade_controle_genius_param_pkg;

    typedef enum logic [4:0] {
        INICIAL           = 5'd0,
        INICIA_SEQUENCIA  = 5'd1,
        CARREGA_DADOS     = 5'd2,
        MOSTRA_DADOS      = 5'd3,
        ZERA_LEDS         = 5'd4,
        MOSTRA_APAGADO    = 5'd5,
        PROXIMA_POSICAO   = 5'd6,
        COMECO_JOGADA     = 5'd7,
        ESPERA_JOGADA     = 5'd8,
        REGISTRA_JOGADA   = 5'd9,
        COMPARA_JOGADA    = 5'd10,
        PASSA_JOGADA      = 5'd11,
        ULTIMA_SEQUENCIA  = 5'd12,
        PROXIMA_SEQUENCIA = 5'd13,
        PERDE_VIDA        = 5'd14,
        ACERTO            = 5'd15,
        ERRO              = 5'd16
    } estado_t;

endpackage

// File: rtl/unidade_controle_genius_param_contador_tmr.sv
// Display/gap/timeout timer: up counter plus the limit compare selected by the current state.
// Latency: counter updates one clock after zera/conta; fim is combinational from count and state.
// Backpressure: none; saturates at all-ones instead of wrapping.
module contador_tmr
    import unidade_controle_genius_param_pkg::*;
#(
    parameter int TMR_W          = 13,
    parameter int DISPLAY_CYCLES = 1000,
    parameter int GAP_CYCLES     = 500,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic    clock,
    input  logic    reset,
    input  logic    zera,
    input  logic    conta,
    input  estado_t estado,
    output logic    fim
);

    localparam logic [TMR_W-1:0] DISPLAY_ULT = TMR_W'(DISPLAY_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_ULT     = TMR_W'(GAP_CYCLES - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_ULT = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [TMR_W-1:0] valor;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valor <= '0;
        end else if (zera) begin
            valor <= '0;
        end else if (conta && (valor != '1)) begin
            valor <= valor + TMR_W'(1);
        end
    end

    // Each timed state compares against its own limit; elsewhere fim is ignored.
    always_comb begin
        fim = 1'b0;
        case (estado)
            MOSTRA_DADOS:   fim = (valor == DISPLAY_ULT);
            MOSTRA_APAGADO: fim = (valor == GAP_ULT);
            ESPERA_JOGADA:  fim = (valor == TIMEOUT_ULT);
            default:        fim = 1'b0;
        endcase
    end

endmodule

// File: rtl/unidade_controle_genius_param.sv
// Control unit for the memory-sequence game: shows the sequence, times plays, tracks lives and hard mode.
// Latency: Moore outputs, one state per clock; timed states last exactly their configured cycle counts.
// Backpressure: none; jogada is a single-cycle pulse consumed only in ESPERA_JOGADA.
module unidade_controle_genius_param
    import unidade_controle_genius_param_pkg::*;
#(
    parameter int DISPLAY_CYCLES = 1000,
    parameter int GAP_CYCLES     = 500,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int MAX_VIDAS      = 3,
    parameter int VIDAS_W        = 2,
    parameter int TMR_W          = 13
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               iniciar,
    input  logic               modo,
    input  logic               jogada,
    input  logic               igual,
    input  logic               enderecoIgualSequencia,
    input  logic               fimS,
    output logic               zeraR,
    output logic               registraR,
    output logic               zeraE,
    output logic               contaE,
    output logic               zeraS,
    output logic               contaS,
    output logic               zeraM,
    output logic               registraM,
    output logic               acertou,
    output logic               errou,
    output logic               pronto,
    output logic [VIDAS_W-1:0] vidas,
    output logic [4:0]         db_estado,
    output logic               db_timeout
);

    localparam logic [VIDAS_W-1:0] VIDAS_INI = VIDAS_W'(MAX_VIDAS);

    estado_t estado, proximo;
    logic    modo_r, timeout_r;
    logic    zeraTMR, contaTMR, fim_tmr;
    logic    carrega_jogo, por_timeout;
    logic    pula_item;

    contador_tmr #(
        .TMR_W          (TMR_W),
        .DISPLAY_CYCLES (DISPLAY_CYCLES),
        .GAP_CYCLES     (GAP_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_tmr (
        .clock  (clock),
        .reset  (reset),
        .zera   (zeraTMR),
        .conta  (contaTMR),
        .estado (estado),
        .fim    (fim_tmr)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado    <= INICIAL;
            vidas     <= VIDAS_INI;
            modo_r    <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            estado    <= proximo;
            timeout_r <= por_timeout;
            if (carrega_jogo) begin
                vidas  <= VIDAS_INI;
                modo_r <= modo;
            end else if ((estado == PERDE_VIDA) && (vidas != '0)) begin
                vidas <= vidas - VIDAS_W'(1);
            end
        end
    end

    // In hard mode older items are walked past silently until E reaches S.
    assign pula_item = modo_r & ~enderecoIgualSequencia;

    always_comb begin
        proximo      = estado;
        zeraR        = 1'b0;
        registraR    = 1'b0;
        zeraE        = 1'b0;
        contaE       = 1'b0;
        zeraS        = 1'b0;
        contaS       = 1'b0;
        zeraM        = 1'b0;
        registraM    = 1'b0;
        acertou      = 1'b0;
        errou        = 1'b0;
        pronto       = 1'b0;
        zeraTMR      = 1'b0;
        contaTMR     = 1'b0;
        carrega_jogo = 1'b0;
        por_timeout  = 1'b0;
        case (estado)
            INICIAL: begin
                zeraR        = 1'b1;
                zeraM        = 1'b1;
                carrega_jogo = 1'b1;
                if (iniciar) proximo = INICIA_SEQUENCIA;
            end
            INICIA_SEQUENCIA: begin
                zeraS   = 1'b1;
                zeraE   = 1'b1;
                proximo = CARREGA_DADOS;
            end
            CARREGA_DADOS: begin
                zeraTMR   = 1'b1;
                registraM = ~pula_item;
                proximo   = pula_item ? PROXIMA_POSICAO : MOSTRA_DADOS;
            end
            MOSTRA_DADOS: begin
                contaTMR = 1'b1;
                if (fim_tmr) proximo = ZERA_LEDS;
            end
            ZERA_LEDS: begin
                zeraTMR = 1'b1;
                zeraM   = 1'b1;
                proximo = MOSTRA_APAGADO;
            end
            MOSTRA_APAGADO: begin
                contaTMR = 1'b1;
                if (fim_tmr) proximo = enderecoIgualSequencia ? COMECO_JOGADA : PROXIMA_POSICAO;
            end
            PROXIMA_POSICAO: begin
                contaE  = 1'b1;
                proximo = CARREGA_DADOS;
            end
            COMECO_JOGADA: begin
                zeraE   = 1'b1;
                zeraR   = 1'b1;
                zeraTMR = 1'b1;
                proximo = ESPERA_JOGADA;
            end
            ESPERA_JOGADA: begin
                contaTMR = 1'b1;
                if (jogada) begin
                    proximo = REGISTRA_JOGADA;
                end else if (fim_tmr) begin
                    proximo     = PERDE_VIDA;
                    por_timeout = 1'b1;
                end
            end
            REGISTRA_JOGADA: begin
                registraR = 1'b1;
                proximo   = COMPARA_JOGADA;
            end
            COMPARA_JOGADA: begin
                if (!igual)                      proximo = PERDE_VIDA;
                else if (enderecoIgualSequencia) proximo = ULTIMA_SEQUENCIA;
                else                             proximo = PASSA_JOGADA;
            end
            PASSA_JOGADA: begin
                contaE  = 1'b1;
                zeraTMR = 1'b1;
                proximo = ESPERA_JOGADA;
            end
            ULTIMA_SEQUENCIA: begin
                proximo = fimS ? ACERTO : PROXIMA_SEQUENCIA;
            end
            PROXIMA_SEQUENCIA: begin
                contaS  = 1'b1;
                zeraE   = 1'b1;
                proximo = CARREGA_DADOS;
            end
            PERDE_VIDA: begin
                zeraE   = 1'b1;
                zeraM   = 1'b1;
                proximo = (vidas == VIDAS_W'(1)) ? ERRO : CARREGA_DADOS;
            end
            ACERTO: begin
                acertou = 1'b1;
                pronto  = 1'b1;
                if (iniciar) begin
                    proximo      = INICIA_SEQUENCIA;
                    carrega_jogo = 1'b1;
                end
            end
            ERRO: begin
                errou  = 1'b1;
                pronto = 1'b1;
                if (iniciar) begin
                    proximo      = INICIA_SEQUENCIA;
                    carrega_jogo = 1'b1;
                end
            end
            default: proximo = INICIAL;
        endcase
    end

    assign db_estado  = estado;
    assign db_timeout = (estado == PERDE_VIDA) & timeout_r;

endmodule

// File: tb/tb_unidade_controle_genius_param.sv
// Bench for the memory-game control unit with a small datapath model and a game-level player/scoreboard.
module tb_unidade_controle_genius_param;

    localparam int DISP = 4;
    localparam int GAP  = 2;
    localparam int TMO  = 10;
    localparam int MAXV = 2;
    localparam int VW   = 2;
    localparam int TW   = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic iniciar = 1'b0, modo = 1'b0, jogada = 1'b0;
    logic igual, enderecoIgualSequencia, fimS;
    logic zeraR, registraR, zeraE, contaE, zeraS, contaS, zeraM, registraM;
    logic acertou, errou, pronto, db_timeout;
    logic [VW-1:0] vidas;
    logic [4:0]    db_estado;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0] mem [4];
    logic [1:0] E, S, jog, play_val, led_val;
    logic       led_on;
    bit         hard_active = 1'b0;

    typedef struct { int val; int len; } win_t;
    win_t obs_q[$];
    int   exp_q[$];
    bit   in_win = 1'b0;
    int   cur_len = 0, cur_val = 0;

    always #5 clock = ~clock;

    unidade_controle_genius_param #(
        .DISPLAY_CYCLES (DISP),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO),
        .MAX_VIDAS      (MAXV),
        .VIDAS_W        (VW),
        .TMR_W          (TW)
    ) dut (
        .clock                  (clock),
        .reset                  (reset),
        .iniciar                (iniciar),
        .modo                   (modo),
        .jogada                 (jogada),
        .igual                  (igual),
        .enderecoIgualSequencia (enderecoIgualSequencia),
        .fimS                   (fimS),
        .zeraR                  (zeraR),
        .registraR              (registraR),
        .zeraE                  (zeraE),
        .contaE                 (contaE),
        .zeraS                  (zeraS),
        .contaS                 (contaS),
        .zeraM                  (zeraM),
        .registraM              (registraM),
        .acertou                (acertou),
        .errou                  (errou),
        .pronto                 (pronto),
        .vidas                  (vidas),
        .db_estado              (db_estado),
        .db_timeout             (db_timeout)
    );

    // Datapath: counters E/S, play register, LED register over a 4-item memory.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            E <= '0; S <= '0; jog <= '0; led_on <= 1'b0; led_val <= '0;
        end else begin
            if (zeraE) E <= '0; else if (contaE) E <= E + 2'd1;
            if (zeraS) S <= '0; else if (contaS) S <= S + 2'd1;
            if (zeraR) jog <= '0; else if (registraR) jog <= play_val;
            if (zeraM) begin
                led_on <= 1'b0; led_val <= '0;
            end else if (registraM) begin
                led_on <= 1'b1; led_val <= mem[E];
            end
        end
    end

    assign igual                  = (jog == mem[E]);
    assign enderecoIgualSequencia = (E == S);
    assign fimS                   = (S == 2'd3);

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Records each lit window (consecutive MOSTRA_DADOS clocks) and polices hard-mode loads.
    always @(negedge clock) begin
        if (db_estado == 5'd3) begin
            if (!in_win) begin
                in_win  = 1'b1;
                cur_len = 1;
                cur_val = int'(led_val);
                check("led_on", int'(led_on), 1);
            end else begin
                cur_len++;
            end
        end else if (in_win) begin
            obs_q.push_back('{val: cur_val, len: cur_len});
            in_win = 1'b0;
        end
        if (hard_active && registraM)
            check("hard_regM_EeqS", int'(E), int'(S));
    end

    task automatic wait_state(input int code, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (int'(db_estado) == code) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (!ok) check($sformatf("wait_state%0d", code), int'(db_estado), code);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    // Plays one full game; err_pct is the chance that any given play is wrong or times out.
    task automatic play_game(input bit hard, input int err_pct);
        int  r, lives, act, d;
        bit  ok, done, replay, adv;
        for (int i = 0; i < 4; i++) mem[i] = 2'($urandom_range(0, 3));
        obs_q.delete();
        exp_q.delete();
        if (!(int'(db_estado) inside {0, 15, 16})) do_reset();
        modo = hard;
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        check("start_state", int'(db_estado), 1);
        check("start_vidas", int'(vidas), MAXV);
        hard_active = hard;
        modo = ~hard;
        lives = MAXV;
        r = 0;
        done = 1'b0;
        while (!done) begin
            if (hard) exp_q.push_back(int'(mem[r]));
            else for (int j = 0; j <= r; j++) exp_q.push_back(int'(mem[j]));
            replay = 1'b0;
            adv = 1'b0;
            for (int k = 0; k <= r && !replay && !done && !adv; k++) begin
                wait_state(8, 400, ok);
                if (!ok) begin
                    hard_active = 1'b0;
                    return;
                end
                act = ($urandom_range(0, 99) < err_pct) ? 1 + int'($urandom_range(0, 1)) : 0;
                if (act == 2) begin
                    repeat (TMO) @(negedge clock);
                    check("timeout_state", int'(db_estado), 14);
                    check("timeout_flag", int'(db_timeout), 1);
                end else begin
                    d = ($urandom_range(0, 3) == 0) ? TMO - 1 : int'($urandom_range(0, TMO - 1));
                    repeat (d) @(negedge clock);
                    check("still_waiting", int'(db_estado), 8);
                    play_val = (act == 0) ? mem[k] : mem[k] + 2'd1;
                    jogada = 1'b1;
                    @(negedge clock);
                    jogada = 1'b0;
                    check("registra_state", int'(db_estado), 9);
                    if (act == 1) begin
                        wait_state(14, 5, ok);
                        if (!ok) begin
                            hard_active = 1'b0;
                            return;
                        end
                        check("wrong_no_timeout", int'(db_timeout), 0);
                    end
                end
                if (act != 0) begin
                    check("vidas_before_loss", int'(vidas), lives);
                    lives--;
                    @(negedge clock);
                    check("vidas_after_loss", int'(vidas), lives);
                    if (lives == 0) begin
                        check("erro_state", int'(db_estado), 16);
                        check("errou", int'(errou), 1);
                        check("pronto_erro", int'(pronto), 1);
                        done = 1'b1;
                    end else begin
                        check("replay_state", int'(db_estado), 2);
                        replay = 1'b1;
                    end
                end else if (k == r) begin
                    if (r == 3) begin
                        wait_state(15, 6, ok);
                        if (ok) begin
                            check("acertou", int'(acertou), 1);
                            check("pronto_acerto", int'(pronto), 1);
                            check("vidas_at_win", int'(vidas), lives);
                        end
                        done = 1'b1;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            if (adv) r++;
        end
        hard_active = 1'b0;
        check("window_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            check("window_len", obs_q[i].len, DISP);
            check("window_val", obs_q[i].val, exp_q[i]);
        end
    endtask

    initial begin
        bit ok;
        #2 reset = 1'b0;
        #1;
        check("rst_state", int'(db_estado), 0);
        check("rst_zeraR", int'(zeraR), 1);
        check("rst_zeraM", int'(zeraM), 1);
        check("rst_zeraE", int'(zeraE), 0);
        check("rst_registraM", int'(registraM), 0);
        check("rst_pronto", int'(pronto), 0);
        check("rst_vidas", int'(vidas), MAXV);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Asynchronous reset while an item is on display.
        for (int i = 0; i < 4; i++) mem[i] = 2'(i);
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        wait_state(3, 20, ok);
        @(negedge clock);
        #1 reset = 1'b0;
        #1;
        check("midrst_state", int'(db_estado), 0);
        check("midrst_zeraR", int'(zeraR), 1);
        check("midrst_zeraM", int'(zeraM), 1);
        check("midrst_contaTMRfree", int'(registraM | contaE | zeraE), 0);
        check("midrst_vidas", int'(vidas), MAXV);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        play_game(1'b0, 0);
        play_game(1'b1, 0);
        for (int g = 0; g < 6; g++) play_game(1'($urandom_range(0, 1)), 25);
        play_game(1'b0, 100);
        check("forced_erro", int'(db_estado), 16);
        play_game(1'b1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
